aes_bus_ctrl: RTL and testbench

Bus-side controller for the AES datapath. It loads a 128-bit block and a 128/192/256-bit key through 32-bit word writes, then sequences one encryption or decryption on an external AES core using a start/done handshake. It captures the result for word readback and reports status and an interrupt. It sits between the host bus and the AES core, and generalises the fixed-128-bit loader with selectable key length, a busy guard, a watchdog and error reporting.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_word_bank.sv | 49 ++++
 rtl/aes_bus_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_aes_bus_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared definitions for the AES bus controller.
//   - word addresses of the register map
//   - controller state encoding
//   - CTRL / STATUS bit positions
//   - key-length legality check used at elaboration
package aes_pkg;

  // Register map (word addresses)
  localparam logic [4:0] ADDR_MSG      = 5'h00;  // 0x00..0x03
  localparam logic [4:0] ADDR_KEY      = 5'h04;  // 0x04..0x0B
  localparam logic [4:0] ADDR_KEY_LAST = 5'h0B;
  localparam logic [4:0] ADDR_CTRL     = 5'h0C;
  localparam logic [4:0] ADDR_STATUS   = 5'h0D;
  localparam logic [4:0] ADDR_RES      = 5'h10;  // 0x10..0x13

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // CTRL bit positions
  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_CLR_ERR = 3;

  // STATUS bit positions
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR_WR = 2;
  localparam int STAT_ERR_TO = 3;

  // AES key lengths the core supports
  function automatic bit key_w_legal(input int w);
    return (w == 128) || (w == 192) || (w == 256);
  endfunction

endpackage

// File: rtl/aes_word_bank.sv
// aes_word_bank: bank of WORDS 32-bit registers, word-addressed on write,
// exposed as one big-endian flattened vector (word 0 in the top bits).
// A parallel load replaces every word at once and has priority over a
// word write.
// Ports:
//   clk, reset  clock, asynchronous active-high reset (clears all words)
//   wr_en       single-word write strobe
//   wr_idx      word index; indices >= WORDS are ignored
//   wdata       word write data
//   load_en     parallel load strobe
//   load_data   parallel load data, big-endian
//   flat        all words, big-endian
module aes_word_bank #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [2:0]            wr_idx,
  input  logic [31:0]           wdata,
  input  logic                  load_en,
  input  logic [32*WORDS-1:0]   load_data,
  output logic [32*WORDS-1:0]   flat
);

  logic [31:0] mem [WORDS];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: this array is a handful of flops, not a RAM macro, so resetting it
  // is cheap and gives defined readback after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= load_data[32*(WORDS-1-i) +: 32];
    end else if (wr_en) begin
      for (int i = 0; i < WORDS; i++) begin
        if (wr_idx == 3'(i)) mem[i] <= wdata;
      end
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < WORDS; i++) flat[32*(WORDS-1-i) +: 32] = mem[i];
  end

endmodule

// File: rtl/aes_bus_ctrl.sv
// aes_bus_ctrl: host-bus front end for an external AES core.
// Loads a 128-bit block and a KEY_W-bit key via 32-bit word writes, runs one
// encrypt/decrypt on the core with a start/done handshake, captures the result
// for readback and reports status plus a level interrupt.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   wr_en, rd_en   bus write / read strobes
//   addr, wdata    word address, write data
//   rdata          registered read data (valid the cycle after rd_en)
//   core_start     one-cycle start pulse to the core
//   core_decrypt   mode to the core (1 = decrypt)
//   core_msg       block to the core
//   core_key       key to the core
//   core_result    core output, valid with core_done
//   core_done      one-cycle completion pulse from the core
//   irq            done & irq_en
module aes_bus_ctrl
  import aes_pkg::*;
#(
  parameter int BUS_W   = 32,
  parameter int KEY_W   = 128,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [4:0]         addr,
  input  logic [BUS_W-1:0]   wdata,
  output logic [BUS_W-1:0]   rdata,
  output logic               core_start,
  output logic               core_decrypt,
  output logic [127:0]       core_msg,
  output logic [KEY_W-1:0]   core_key,
  input  logic [127:0]       core_result,
  input  logic               core_done,
  output logic               irq
);

  localparam int KEY_WORDS = KEY_W / 32;
  localparam int WD_W      = $clog2(TIMEOUT);

  if (BUS_W != 32) begin : g_bad_bus_w
    $error("aes_bus_ctrl: BUS_W must be 32");
  end
  if (!key_w_legal(KEY_W)) begin : g_bad_key_w
    $error("aes_bus_ctrl: KEY_W must be 128, 192 or 256");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("aes_bus_ctrl: TIMEOUT must be at least 2");
  end

  state_t          state, state_nxt;
  logic            decrypt_q, irq_en_q, done_q, err_wr_q, err_to_q;
  logic [WD_W-1:0] wd;
  logic [127:0]    res_flat;
  logic [BUS_W-1:0] rd_next;

  // Bus decode
  logic busy, wr_msg, wr_key, wr_ctrl, clr_req, blocked;
  logic msg_we, key_we, ctrl_we, start_req, capture, timeout_hit;

  assign busy    = (state == START) || (state == RUN);
  assign wr_msg  = wr_en && (addr[4:2] == 3'b000);
  assign wr_key  = wr_en && (addr >= ADDR_KEY) && (addr <= ADDR_KEY_LAST);
  assign wr_ctrl = wr_en && (addr == ADDR_CTRL);
  assign clr_req = wr_ctrl && wdata[CTRL_CLR_ERR];

  // A clear-error CTRL write is the one write honoured while busy; it does
  // nothing else in that case (start/decrypt/irq_en are dropped silently).
  assign blocked   = busy && (wr_msg || wr_key || (wr_ctrl && !clr_req));
  assign msg_we    = wr_msg && !busy;
  assign key_we    = wr_key && !busy;
  assign ctrl_we   = wr_ctrl && !busy;
  assign start_req = ctrl_we && wdata[CTRL_START];

  // Done beats the watchdog when both land on the same edge.
  assign capture     = (state == RUN) && core_done;
  assign timeout_hit = (state == RUN) && !core_done && (wd == WD_W'(TIMEOUT - 1));

  aes_word_bank #(.WORDS(4)) u_msg (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (msg_we),
    .wr_idx    ({1'b0, addr[1:0]}),
    .wdata     (wdata),
    .load_en   (1'b0),
    .load_data ('0),
    .flat      (core_msg)
  );

  // Key addresses 0x04..0x0B map to indices 0..7 by subtracting 4 modulo 8.
  aes_word_bank #(.WORDS(KEY_WORDS)) u_key (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (key_we),
    .wr_idx    (addr[2:0] - 3'd4),
    .wdata     (wdata),
    .load_en   (1'b0),
    .load_data ('0),
    .flat      (core_key)
  );

  aes_word_bank #(.WORDS(4)) u_res (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_idx    (3'd0),
    .wdata     (32'd0),
    .load_en   (capture),
    .load_data (core_result),
    .flat      (res_flat)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: the default assignment first means every path assigns state_nxt,
  // so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_req) state_nxt = START;
      START:      state_nxt = RUN;
      RUN: begin
        if (capture)          state_nxt = DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default:    state_nxt = IDLE;
    endcase
  end

  // Control / status flags and watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decrypt_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_wr_q  <= 1'b0;
      err_to_q  <= 1'b0;
      wd        <= '0;
    end else begin
      if (ctrl_we) begin
        decrypt_q <= wdata[CTRL_DECRYPT];
        irq_en_q  <= wdata[CTRL_IRQ_EN];
      end

      if (start_req)    done_q <= 1'b0;
      else if (capture) done_q <= 1'b1;

      // blocked and clr_req never come from the same write
      if (blocked)      err_wr_q <= 1'b1;
      else if (clr_req) err_wr_q <= 1'b0;

      if (timeout_hit)  err_to_q <= 1'b1;
      else if (clr_req) err_to_q <= 1'b0;

      if (state == START)    wd <= '0;
      else if (state == RUN) wd <= wd + WD_W'(1);
    end
  end

  // Read mux; rdata registers the pre-edge value, so a same-cycle write to
  // the address being read returns the old contents.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < 4; i++) begin
      if (addr == ADDR_MSG + 5'(i)) rd_next = core_msg[32*(3-i) +: 32];
      if (addr == ADDR_RES + 5'(i)) rd_next = res_flat[32*(3-i) +: 32];
    end
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (addr == ADDR_KEY + 5'(i)) rd_next = core_key[32*(KEY_WORDS-1-i) +: 32];
    end
    if (addr == ADDR_CTRL) begin
      rd_next[CTRL_DECRYPT] = decrypt_q;
      rd_next[CTRL_IRQ_EN]  = irq_en_q;
    end
    if (addr == ADDR_STATUS) begin
      rd_next[STAT_BUSY]   = busy;
      rd_next[STAT_DONE]   = done_q;
      rd_next[STAT_ERR_WR] = err_wr_q;
      rd_next[STAT_ERR_TO] = err_to_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= rd_next;
  end

  assign core_start   = (state == START);
  assign core_decrypt = decrypt_q;
  assign irq          = done_q & irq_en_q;

endmodule

// File: tb/tb_aes_bus_ctrl.sv
// Directed testbench for aes_bus_ctrl. Instance dut uses KEY_W=128 and
// TIMEOUT=16; instance dut_b uses KEY_W=256 and shares all inputs, so key
// writes to 0x08..0x0B land only in dut_b. The bench plays the AES core by
// driving core_done / core_result at chosen edges.
module tb_aes_bus_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en, rd_en;
  logic [4:0]   addr;
  logic [31:0]  wdata;
  logic [127:0] core_result;
  logic         core_done;

  logic [31:0]  rdata;
  logic         core_start, core_decrypt, irq;
  logic [127:0] core_msg, core_key;

  logic [31:0]  rdata_b;
  logic         core_start_b, core_decrypt_b, irq_b;
  logic [127:0] core_msg_b;
  logic [255:0] core_key_b;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] MSG  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] KEY  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [255:0] KEY8 = 256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [127:0] RES1 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] RES2 = 128'h01234567_89abcdef_fedcba98_76543210;

  always #5 clk = ~clk;

  aes_bus_ctrl #(.BUS_W(32), .KEY_W(128), .TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .core_start   (core_start),
    .core_decrypt (core_decrypt),
    .core_msg     (core_msg),
    .core_key     (core_key),
    .core_result  (core_result),
    .core_done    (core_done),
    .irq          (irq)
  );

  aes_bus_ctrl #(.BUS_W(32), .KEY_W(256), .TIMEOUT(16)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata_b),
    .core_start   (core_start_b),
    .core_decrypt (core_decrypt_b),
    .core_msg     (core_msg_b),
    .core_key     (core_key_b),
    .core_result  (core_result),
    .core_done    (core_done),
    .irq          (irq_b)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bench actions happen 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic core_reply(input logic [127:0] r);
    core_done   = 1'b1;
    core_result = r;
    tick();
    core_done   = 1'b0;
    core_result = '0;
  endtask

  initial begin
    reset       = 1'b1;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    addr        = '0;
    wdata       = '0;
    core_result = '0;
    core_done   = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_rdata",   rdata, 0);
    check("rst_start",   core_start, 0);
    check("rst_decrypt", core_decrypt, 0);
    check("rst_irq",     irq, 0);
    check("rst_msg",     core_msg, 0);
    check("rst_key",     core_key, 0);
    reset = 1'b0;
    tick();
    bus_read(5'h0D);
    check("rst_status", rdata, 0);

    // Key words 0x04..0x0B; only dut_b holds eight of them
    for (int i = 0; i < 8; i++) begin
      bus_write(5'(4 + i), {8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)});
    end
    check("key256_order", core_key_b, KEY8);
    check("key128_value", core_key, KEY);
    bus_read(5'h08);
    check("key128_rd_0x08", rdata, 0);
    check("key256_rd_0x08", rdata_b, 32'h10111213);

    // Message
    bus_write(5'h00, 32'h00112233);
    bus_write(5'h01, 32'h44556677);
    bus_write(5'h02, 32'h8899aabb);
    bus_write(5'h03, 32'hccddeeff);
    check("msg_value", core_msg, MSG);

    // Encrypt with irq_en; core replies 10 cycles after start
    bus_write(5'h0C, 32'h5);
    check("enc_start_hi", core_start, 1);
    check("enc_mode",     core_decrypt, 0);
    tick();
    check("enc_start_lo", core_start, 0);
    repeat (9) tick();
    core_reply(RES1);
    check("enc_irq", irq, 1);
    bus_read(5'h0D);
    check("enc_status", rdata, 32'h2);
    bus_read(5'h10);
    check("enc_res_w0", rdata, 32'h69c4e0d8);
    bus_read(5'h11);
    check("enc_res_w1", rdata, 32'h6a7b0430);
    bus_read(5'h12);
    check("enc_res_w2", rdata, 32'hd8cdb780);
    bus_read(5'h13);
    check("enc_res_w3", rdata, 32'h70b4c55a);
    bus_read(5'h0C);
    check("ctrl_readback", rdata, 32'h4);

    // Same-cycle write and read of one address returns the old word
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = 5'h01;
    wdata = 32'hcafef00d;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    check("rw_same_old", rdata, 32'h44556677);
    bus_read(5'h01);
    check("rw_same_new", rdata, 32'hcafef00d);
    bus_write(5'h01, 32'h44556677);

    // Decrypt run: blocked write, clear while busy, then watchdog timeout
    bus_write(5'h0C, 32'h3);            // start at edge N
    check("dec_start_hi", core_start, 1);
    check("dec_mode",     core_decrypt, 1);
    check("dec_irq_lo",   irq, 0);
    bus_write(5'h00, 32'hdeadbeef);     // edge N+1, busy -> dropped
    check("dec_start_lo", core_start, 0);
    bus_read(5'h0D);                    // edge N+2
    check("errwr_status", rdata, 32'h5);
    check("errwr_msg_kept", core_msg, MSG);
    bus_write(5'h0C, 32'h8);            // edge N+3, clear while busy
    bus_read(5'h0D);                    // edge N+4
    check("clr_busy_status", rdata, 32'h1);
    repeat (12) tick();                 // edges N+5..N+16
    bus_read(5'h0D);                    // edge N+17 samples last RUN cycle
    check("to_before", rdata, 32'h1);
    bus_read(5'h0D);                    // edge N+18, IDLE with err_to
    check("to_after", rdata, 32'h8);
    core_reply(RES2);                   // late done in IDLE is ignored
    bus_read(5'h0D);
    check("to_late_done", rdata, 32'h8);
    bus_read(5'h10);
    check("to_res_kept", rdata, 32'h69c4e0d8);
    bus_read(5'h00);
    check("to_msg_w0", rdata, 32'h00112233);

    // core_done on the same edge the watchdog would expire
    bus_write(5'h0C, 32'h8);
    bus_write(5'h0C, 32'h1);            // start at edge P
    repeat (16) tick();                 // edges P+1..P+16
    core_reply(RES2);                   // sampled at edge P+17
    bus_read(5'h0D);
    check("race_status", rdata, 32'h2);
    bus_read(5'h13);
    check("race_res_w3", rdata, 32'h76543210);

    // Reset in the middle of a run
    bus_write(5'h0C, 32'h7);
    check("rr_mode", core_decrypt, 1);
    bus_read(5'h0D);                    // START -> RUN on this edge
    check("rr_busy_rd", rdata, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rr_rdata",   rdata, 0);
    check("rr_start",   core_start, 0);
    check("rr_decrypt", core_decrypt, 0);
    check("rr_irq",     irq, 0);
    check("rr_msg",     core_msg, 0);
    check("rr_key",     core_key, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    core_reply(RES1);
    bus_read(5'h0D);
    check("rr_status", rdata, 0);
    bus_read(5'h10);
    check("rr_res_w0", rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
